execute_branch_check: RTL and testbench

- Execute-stage consumer of the 5-bit architectural flag vector.
- Evaluates a conditional-branch condition code against the current flags, with same-cycle bypass from the in-flight flag producer.
- Compares the result with the fetch-time prediction and registers a one-entry branch result with redirect address toward writeback/fetch.
- Keeps a saturating mispredict counter for the performance-monitor sysreg.

---
 rtl/execute_branch_check_pkg.sv | 54 +++++
 rtl/execute_branch_cc_eval.sv | 18 +
 rtl/execute_branch_check.sv | 115 +++++++++++
 tb/tb_execute_branch_check.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_branch_check_pkg.sv
// Shared definitions for the execute-stage branch check: flag bit map,
// condition codes and the condition evaluator used by RTL and predictor models.
package execute_branch_check_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_P = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_O = 3;
    localparam int FLAG_S = 4;

    typedef enum logic [3:0] {
        CC_ALWAYS = 4'd0,
        CC_EQ     = 4'd1,
        CC_NE     = 4'd2,
        CC_MI     = 4'd3,
        CC_PL     = 4'd4,
        CC_PAR    = 4'd5,
        CC_NPAR   = 4'd6,
        CC_OV     = 4'd7,
        CC_NOV    = 4'd8,
        CC_CS     = 4'd9,
        CC_CC     = 4'd10,
        CC_HI     = 4'd11,
        CC_LS     = 4'd12,
        CC_GT     = 4'd13,
        CC_GE     = 4'd14,
        CC_LT     = 4'd15
    } cc_e;

    function automatic logic cc_eval(input logic [3:0] cc, input logic [4:0] flags);
        logic res;
        case (cc)
            CC_ALWAYS: res = 1'b1;
            CC_EQ:     res = flags[FLAG_Z];
            CC_NE:     res = !flags[FLAG_Z];
            CC_MI:     res = flags[FLAG_S];
            CC_PL:     res = !flags[FLAG_S];
            CC_PAR:    res = flags[FLAG_P];
            CC_NPAR:   res = !flags[FLAG_P];
            CC_OV:     res = flags[FLAG_O];
            CC_NOV:    res = !flags[FLAG_O];
            CC_CS:     res = flags[FLAG_C];
            CC_CC:     res = !flags[FLAG_C];
            CC_HI:     res = flags[FLAG_C] && !flags[FLAG_Z];
            CC_LS:     res = !flags[FLAG_C] || flags[FLAG_Z];
            CC_GT:     res = !flags[FLAG_Z] && (flags[FLAG_S] == flags[FLAG_O]);
            CC_GE:     res = (flags[FLAG_S] == flags[FLAG_O]);
            CC_LT:     res = (flags[FLAG_S] != flags[FLAG_O]);
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_branch_cc_eval.sv
// Combinational flag bypass and condition-code decode for the branch check.
module execute_branch_cc_eval
    import execute_branch_check_pkg::*;
(
    input  logic [4:0] flag_i,
    input  logic       fwd_valid_i,
    input  logic [4:0] fwd_flag_i,
    input  logic [3:0] cc_i,
    output logic       cond_o
);

    logic [4:0] eff_flag_s;

    // In-flight flag writes win so a compare followed directly by a branch sees new flags.
    assign eff_flag_s = fwd_valid_i ? fwd_flag_i : flag_i;
    assign cond_o     = cc_eval(cc_i, eff_flag_s);

endmodule

// File: rtl/execute_branch_check.sv
// Execute-stage branch resolution: one registered result entry with redirect
// address, valid/busy handshake and a saturating mispredict counter.
module execute_branch_check
    import execute_branch_check_pkg::*;
#(
    parameter int P_ADDR_W     = 32,
    parameter int P_INST_BYTES = 4,
    parameter int P_CNT_W      = 16
) (
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    input  logic                iCTRL_HOLD,
    input  logic                iEVENT_FLUSH,
    input  logic                iPREV_VALID,
    output logic                oPREV_BUSY,
    input  logic                iPREV_BRANCH,
    input  logic [3:0]          iPREV_CC,
    input  logic [P_ADDR_W-1:0] iPREV_PC,
    input  logic [P_ADDR_W-1:0] iPREV_TARGET,
    input  logic                iPREV_PREDICT,
    input  logic [4:0]          iFLAG,
    input  logic                iFWD_VALID,
    input  logic [4:0]          iFWD_FLAG,
    output logic                oNEXT_VALID,
    input  logic                iNEXT_BUSY,
    output logic                oNEXT_BRANCH,
    output logic                oNEXT_TAKEN,
    output logic                oNEXT_MISPREDICT,
    output logic [P_ADDR_W-1:0] oNEXT_REDIRECT,
    output logic [P_CNT_W-1:0]  oMISS_COUNT
);

    localparam logic [P_CNT_W-1:0]  CNT_MAX   = {P_CNT_W{1'b1}};
    localparam logic [P_ADDR_W-1:0] INST_STEP = P_ADDR_W'(P_INST_BYTES);

    logic                valid_q, valid_d;
    logic                branch_q, branch_d;
    logic                taken_q, taken_d;
    logic                mispred_q, mispred_d;
    logic [P_ADDR_W-1:0] redirect_q, redirect_d;
    logic [P_CNT_W-1:0]  cnt_q, cnt_d;

    logic cond_s;
    logic taken_s;
    logic mispred_s;
    logic stall_s;
    logic accept_s;

    execute_branch_cc_eval u_cc_eval (
        .flag_i      (iFLAG),
        .fwd_valid_i (iFWD_VALID),
        .fwd_flag_i  (iFWD_FLAG),
        .cc_i        (iPREV_CC),
        .cond_o      (cond_s)
    );

    assign stall_s   = valid_q && iNEXT_BUSY;
    assign accept_s  = iPREV_VALID && !stall_s && !iCTRL_HOLD && !iEVENT_FLUSH;
    assign taken_s   = iPREV_BRANCH && cond_s;
    assign mispred_s = iPREV_BRANCH && (cond_s != iPREV_PREDICT);

    // Next-state selection by flush > hold > stall > load priority.
    always_comb begin
        valid_d    = valid_q;
        branch_d   = branch_q;
        taken_d    = taken_q;
        mispred_d  = mispred_q;
        redirect_d = redirect_q;
        cnt_d      = cnt_q;
        if (iEVENT_FLUSH) begin
            valid_d = 1'b0;
        end else if (iCTRL_HOLD || stall_s) begin
            valid_d = valid_q;
        end else begin
            valid_d    = accept_s;
            branch_d   = iPREV_BRANCH;
            taken_d    = taken_s;
            mispred_d  = mispred_s;
            redirect_d = taken_s ? iPREV_TARGET : (iPREV_PC + INST_STEP);
            if (accept_s && mispred_s && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + {{(P_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Result entry and counter registers with synchronous reset.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            valid_q    <= 1'b0;
            branch_q   <= 1'b0;
            taken_q    <= 1'b0;
            mispred_q  <= 1'b0;
            redirect_q <= {P_ADDR_W{1'b0}};
            cnt_q      <= {P_CNT_W{1'b0}};
        end else begin
            valid_q    <= valid_d;
            branch_q   <= branch_d;
            taken_q    <= taken_d;
            mispred_q  <= mispred_d;
            redirect_q <= redirect_d;
            cnt_q      <= cnt_d;
        end
    end

    assign oPREV_BUSY       = stall_s;
    assign oNEXT_VALID      = valid_q;
    assign oNEXT_BRANCH     = branch_q;
    assign oNEXT_TAKEN      = taken_q;
    assign oNEXT_MISPREDICT = mispred_q;
    assign oNEXT_REDIRECT   = redirect_q;
    assign oMISS_COUNT      = cnt_q;

endmodule

// File: tb/tb_execute_branch_check.sv
// Self-checking bench for execute_branch_check: directed scenarios, full
// condition-code sweep and randomized traffic against a transaction-level model.
module tb_execute_branch_check;

    logic        clk = 1'b0;
    logic        rst, hold, flush, pvalid, pbranch, pred, fwdv, nbusy;
    logic [3:0]  cc;
    logic [31:0] pc, target;
    logic [4:0]  flag, fwdf;

    logic        busy, ov, ob, ot, om;
    logic [31:0] oredir;
    logic [15:0] ocnt;
    logic        busy4, ov4, ob4, ot4, om4;
    logic [31:0] oredir4;
    logic [3:0]  ocnt4;

    int checks = 0;
    int errors = 0;

    // model of the architectural result entry
    logic        ev, eb, et, em, known;
    logic [31:0] er;
    logic [15:0] ecnt;
    logic [3:0]  ecnt4;

    always #5 clk = ~clk;

    execute_branch_check dut (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iCTRL_HOLD(hold), .iEVENT_FLUSH(flush),
        .iPREV_VALID(pvalid), .oPREV_BUSY(busy), .iPREV_BRANCH(pbranch),
        .iPREV_CC(cc), .iPREV_PC(pc), .iPREV_TARGET(target), .iPREV_PREDICT(pred),
        .iFLAG(flag), .iFWD_VALID(fwdv), .iFWD_FLAG(fwdf),
        .oNEXT_VALID(ov), .iNEXT_BUSY(nbusy), .oNEXT_BRANCH(ob), .oNEXT_TAKEN(ot),
        .oNEXT_MISPREDICT(om), .oNEXT_REDIRECT(oredir), .oMISS_COUNT(ocnt)
    );

    execute_branch_check #(.P_CNT_W(4)) dut4 (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iCTRL_HOLD(hold), .iEVENT_FLUSH(flush),
        .iPREV_VALID(pvalid), .oPREV_BUSY(busy4), .iPREV_BRANCH(pbranch),
        .iPREV_CC(cc), .iPREV_PC(pc), .iPREV_TARGET(target), .iPREV_PREDICT(pred),
        .iFLAG(flag), .iFWD_VALID(fwdv), .iFWD_FLAG(fwdf),
        .oNEXT_VALID(ov4), .iNEXT_BUSY(nbusy), .oNEXT_BRANCH(ob4), .oNEXT_TAKEN(ot4),
        .oNEXT_MISPREDICT(om4), .oNEXT_REDIRECT(oredir4), .oMISS_COUNT(ocnt4)
    );

    function automatic logic ref_cc(input int c, input logic [4:0] f);
        logic z, p, cy, o, s;
        z = f[0]; p = f[1]; cy = f[2]; o = f[3]; s = f[4];
        case (c)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return s;
            4:  return !s;
            5:  return p;
            6:  return !p;
            7:  return o;
            8:  return !o;
            9:  return cy;
            10: return !cy;
            11: return cy && !z;
            12: return !cy || z;
            13: return !z && (s == o);
            14: return s == o;
            15: return s != o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: predict the next entry from current inputs, then compare
    task automatic step();
        logic nv, nb, nt, nm, nk;
        logic [31:0] nr;
        logic [15:0] nc;
        logic [3:0]  nc4;
        nv = ev; nb = eb; nt = et; nm = em; nr = er; nk = known; nc = ecnt; nc4 = ecnt4;
        #1;
        chk("prev_busy", {31'd0, busy}, {31'd0, ev && nbusy});
        if (rst) begin
            nv = 0; nb = 0; nt = 0; nm = 0; nr = 0; nc = 0; nc4 = 0; nk = 1;
        end else if (flush) begin
            nv = 0; nk = 0;
        end else if (hold || (ev && nbusy)) begin
            nk = known;
        end else begin
            nv = pvalid;
            nb = pbranch;
            nt = pbranch && ref_cc(int'(cc), fwdv ? fwdf : flag);
            nm = pbranch && (nt != pred);
            nr = nt ? target : pc + 32'd4;
            nk = 1;
            if (pvalid && nm) begin
                if (nc != 16'hFFFF) nc = nc + 16'd1;
                if (nc4 != 4'hF) nc4 = nc4 + 4'd1;
            end
        end
        @(posedge clk);
        #1;
        ev = nv; eb = nb; et = nt; em = nm; er = nr; known = nk; ecnt = nc; ecnt4 = nc4;
        chk("valid", {31'd0, ov}, {31'd0, ev});
        chk("count", {16'd0, ocnt}, {16'd0, ecnt});
        chk("count4", {28'd0, ocnt4}, {28'd0, ecnt4});
        chk("valid4", {31'd0, ov4}, {31'd0, ev});
        if (known) begin
            chk("branch", {31'd0, ob}, {31'd0, eb});
            chk("taken", {31'd0, ot}, {31'd0, et});
            chk("mispredict", {31'd0, om}, {31'd0, em});
            chk("redirect", oredir, er);
            chk("redirect4", oredir4, er);
        end
    endtask

    task automatic set_br(input logic [3:0] c, input logic [31:0] a, input logic [31:0] t,
                          input logic p);
        pvalid = 1; pbranch = 1; cc = c; pc = a; target = t; pred = p;
    endtask

    initial begin
        logic [31:0] keep;
        ev = 0; eb = 0; et = 0; em = 0; er = 0; ecnt = 0; ecnt4 = 0; known = 0;
        rst = 1; hold = 0; flush = 0; pvalid = 0; pbranch = 0; cc = 0; pc = 0;
        target = 0; pred = 0; flag = 0; fwdv = 0; fwdf = 0; nbusy = 0;
        step(); step();
        rst = 0;
        chk("rst_valid", {31'd0, ov}, 32'd0);
        chk("rst_redirect", oredir, 32'd0);
        chk("rst_count", {16'd0, ocnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // bypass: committed Z=0 but forwarded Z=1
        set_br(4'd1, 32'h100, 32'h200, 1'b0);
        flag = 5'h00; fwdv = 1; fwdf = 5'h01;
        step();
        chk("byp_taken", {31'd0, ot}, 32'd1);
        chk("byp_mis", {31'd0, om}, 32'd1);
        chk("byp_redir", oredir, 32'h200);
        chk("byp_count", {16'd0, ocnt}, 32'd1);

        // committed flags, GE then LT
        fwdv = 0; fwdf = 5'h00; flag = 5'h18;
        set_br(4'd14, 32'h300, 32'h400, 1'b1);
        step();
        chk("ge_taken", {31'd0, ot}, 32'd1);
        chk("ge_count", {16'd0, ocnt}, 32'd1);
        cc = 4'd15;
        step();
        chk("lt_taken", {31'd0, ot}, 32'd0);
        chk("lt_redir", oredir, 32'h304);
        chk("lt_count", {16'd0, ocnt}, 32'd2);

        // downstream stall with a new input waiting
        nbusy = 1;
        set_br(4'd0, 32'h500, 32'h600, 1'b0);
        repeat (3) step();
        chk("stall_redir", oredir, 32'h304);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        nbusy = 0;
        step();
        chk("rel_redir", oredir, 32'h600);
        pvalid = 0;
        step();
        chk("rel_count", {16'd0, ocnt}, 32'd3);

        // flush drops an incoming mispredict
        set_br(4'd0, 32'h700, 32'h800, 1'b0);
        flush = 1;
        step();
        flush = 0;
        chk("flush_valid", {31'd0, ov}, 32'd0);
        chk("flush_count", {16'd0, ocnt}, 32'd3);

        // hold freezes a loaded entry
        step();
        keep = oredir;
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_br(4'($urandom), $urandom, $urandom, 1'($urandom));
            nbusy = 1'($urandom);
            step();
        end
        chk("hold_redir", oredir, keep);
        hold = 0; nbusy = 0;

        // every condition code against every flag value
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                set_br(4'(c), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 1'($urandom));
                fwdv = 1'($urandom);
                flag = fwdv ? 5'($urandom) : 5'(f);
                fwdf = fwdv ? 5'(f) : 5'($urandom);
                step();
            end
        end

        // saturation of the 4-bit counter
        rst = 1; pvalid = 0; fwdv = 0;
        step();
        rst = 0;
        for (int i = 0; i < 17; i++) begin
            set_br(4'd0, 32'h40, 32'h80, 1'b0);
            step();
        end
        chk("sat_count4", {28'd0, ocnt4}, 32'hF);
        chk("sat_count16", {16'd0, ocnt}, 32'd17);

        // fall-through wraps at the top of the address space
        flag = 5'h01;
        set_br(4'd2, 32'hFFFF_FFFC, 32'h1234, 1'b0);
        step();
        chk("wrap_redir", oredir, 32'h0);

        // reset while a valid entry is stalled
        nbusy = 1;
        step();
        rst = 1;
        step();
        rst = 0; nbusy = 0; pvalid = 0;
        chk("rst_stall_valid", {31'd0, ov}, 32'd0);
        chk("rst_stall_redir", oredir, 32'd0);
        chk("rst_stall_count", {16'd0, ocnt}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 99) < 2);
            flush   = ($urandom_range(0, 99) < 6);
            hold    = ($urandom_range(0, 99) < 10);
            nbusy   = ($urandom_range(0, 99) < 30);
            pvalid  = ($urandom_range(0, 99) < 80);
            pbranch = ($urandom_range(0, 99) < 75);
            cc = 4'($urandom); pred = 1'($urandom);
            pc = $urandom; target = $urandom;
            flag = 5'($urandom); fwdv = 1'($urandom); fwdf = 5'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
